formant_frame_scheduler: RTL and testbench
==========================================

# formant_frame_scheduler

Frame-level controller in front of the formant extraction engine. Splits the incoming FFT magnitude stream into frames of I beats, admits one frame at a time into the engine, drops frames that arrive while the engine or result register is occupied, and latches the engine's formant result into a valid/ready output register. An optional watchdog pulses an engine reset and recovers the scheduler if the engine never reports a result.

## Interface
- BIT_WIDTH, 32, width of FFT samples and formant frequencies
- I, 160, beats per frame; must be ≥ 2
- FORMANTS, 5, formant values per result
- TIMEOUT_CYCLES, 1000000, watchdog limit in WAIT_ENG
- CNT_WIDTH, 16, width of the drop and timeout counters
- clk_in  in  1  single clock; all logic is on the rising edge
- rst_in  in  1  asynchronous, active-high reset
- fft_valid  in  1  input sample strobe; gaps between beats are allowed
- fft_data  in  BIT_WIDTH  input sample
- eng_fft_valid  out  1  sample strobe to the engine
- eng_fft_data  out  BIT_WIDTH  sample to the engine
- eng_rst  out  1  engine soft reset
- eng_formant_valid  in  1  one-cycle result pulse from the engine
- eng_formant_freq  in  BIT_WIDTH*FORMANTS  engine result; formant k is at bits [k*BIT_WIDTH +: BIT_WIDTH]
- res_valid  out  1  output register full
- res_ready  in  1  consumer accept
- res_freq  out  BIT_WIDTH*FORMANTS  latched result
- res_seq  out  8  sequence tag of the frame that produced res_freq
- busy  out  1  high when state ≠ IDLE
- drop_count  out  CNT_WIDTH  frames dropped; saturates at all-ones
- timeout_count  out  CNT_WIDTH  watchdog expiries; saturates at all-ones

## Operation
- **Beat counter**
  - in_cnt counts fft_valid beats 0..I-1 and wraps at I-1 → 0, independent of state.
  - A frame start is a beat with in_cnt == 0.
- **Admission**
  - A frame is accepted when its start beat arrives with state == IDLE and the output register free.
  - The output register is free when res_valid == 0, or when res_valid && res_ready in the same cycle.
  - On acceptance: tag := accept_seq; accept_seq increments (8-bit wrap); state goes to FORWARD.
  - A start beat arriving under any other condition drops the frame: drop_count + 1, and none of that frame's beats are forwarded.
- **States**
  - IDLE: no forwarding.
  - FORWARD: every fft_valid beat, starting with the start beat, is copied to the engine. After the beat with in_cnt == I-1 is forwarded, go to WAIT_ENG and clear the watchdog counter.
  - WAIT_ENG: on eng_formant_valid, load res_freq := eng_formant_freq, res_seq := tag, res_valid := 1, and go to IDLE. An eng_formant_valid pulse in any other state is ignored.
  - RECOVER: eng_rst is held high for 4 cycles, then go to IDLE.
- **Output handshake**
  - res_valid clears on res_valid && res_ready.
  - Loading a new result and popping the old one in the same cycle leaves res_valid = 1 holding the new data.
  - res_freq and res_seq are stable while res_valid && !res_ready.
- **Counters**: drop_count and timeout_count saturate at all-ones and never wrap.

## Timing
- **Reset values**: eng_fft_valid, eng_fft_data, eng_rst, res_valid, res_freq, res_seq, drop_count and timeout_count are all 0; busy = 0; state = IDLE; in_cnt = 0; accept_seq = 0.
- **Forward path**: one cycle. eng_fft_valid/eng_fft_data at cycle t+1 equal fft_valid/fft_data at cycle t. Input gaps are reproduced exactly.
- **Result path**: res_valid rises the cycle after the eng_formant_valid pulse.
- **Earliest next frame**: the next start beat can be accepted in the cycle after the return to IDLE, provided the output register is free.
- **Reset mid-frame**: rst_in asserted at any point returns every register to its reset value immediately. in_cnt restarts at 0, so the next fft_valid beat is treated as a frame start.

## Configuration
- FORMANT_SCHED_TIMEOUT_EN defined:
  - The watchdog counts cycles in WAIT_ENG.
  - When the count reaches TIMEOUT_CYCLES: timeout_count + 1, go to RECOVER.
  - res_valid is not set by a timeout.
- Not defined:
  - There is no watchdog counter; WAIT_ENG waits indefinitely.
  - RECOVER is unreachable, eng_rst is constant 0, and timeout_count is constant 0.

## Test plan
Bench parameters for all scenarios: I=8, FORMANTS=5, TIMEOUT_CYCLES=50.
- **Single frame**: 8 contiguous beats with data 1..8; engine pulse 20 cycles later carrying {100,200,300,400,500}.
  - eng_fft_data is 1..8, delayed one cycle.
  - res_valid=1 the cycle after the pulse; res_freq = {100,200,300,400,500}; res_seq=0; busy low afterwards.
- **Drop while busy**: second frame starts during WAIT_ENG.
  - drop_count=1; eng_fft_valid stays 0 for that frame; next accepted frame gets res_seq=1.
- **Output backpressure**: res_ready=0 holding the first result; a new frame starts.
  - Frame is dropped; drop_count=1; res_freq unchanged.
  - Assert res_ready: res_valid falls next cycle; the following frame is accepted.
- **Input gaps**: 8 beats with fft_valid toggling 1,0,1,0…
  - Forwarded strobe reproduces the same pattern one cycle late; state reaches WAIT_ENG after beat 8.
- **Watchdog**: with FORMANT_SCHED_TIMEOUT_EN, no engine pulse.
  - After 50 cycles in WAIT_ENG: timeout_count=1, eng_rst high for exactly 4 cycles, then IDLE; res_valid stays 0.
  - Without the macro, the bench stays in WAIT_ENG past 200 cycles.
- **Async reset mid-FORWARD**: rst_in pulsed at beat 4.
  - All outputs return to 0 with no clock edge.
  - The next 8 beats are accepted as a new frame with res_seq=0.

Source files
------------

// File: rtl/formant_frame_scheduler.sv
// Frame scheduler for the formant engine: frames the FFT stream, admits one frame at a time,
// drops the rest and registers results. Optional watchdog: define FORMANT_SCHED_TIMEOUT_EN.
module formant_frame_scheduler #(
  parameter int BIT_WIDTH      = 32,
  parameter int I              = 160,
  parameter int FORMANTS       = 5,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          fft_valid,
  input  logic [BIT_WIDTH-1:0]          fft_data,
  output logic                          eng_fft_valid,
  output logic [BIT_WIDTH-1:0]          eng_fft_data,
  output logic                          eng_rst,
  input  logic                          eng_formant_valid,
  input  logic [BIT_WIDTH*FORMANTS-1:0] eng_formant_freq,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [BIT_WIDTH*FORMANTS-1:0] res_freq,
  output logic [7:0]                    res_seq,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic [CNT_WIDTH-1:0]          timeout_count
);

  localparam int CW = $clog2(I);
  localparam int FW = BIT_WIDTH * FORMANTS;
  localparam logic [CW-1:0] LAST_BEAT = CW'(I - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FORWARD,
    ST_WAIT_ENG,
    ST_RECOVER
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          in_cnt_q, in_cnt_d;
  logic [7:0]             accept_seq_q;
  logic [7:0]             tag_q;
  logic                   eng_fft_valid_q;
  logic [BIT_WIDTH-1:0]   eng_fft_data_q;
  logic                   res_valid_q;
  logic [FW-1:0]          res_freq_q;
  logic [7:0]             res_seq_q;
  logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;

  logic start_beat, out_free, accept, drop, forward, pop, load;

  assign start_beat = fft_valid && (in_cnt_q == '0);
  // The output register counts as free when it is being popped this very cycle.
  assign out_free   = !res_valid_q || res_ready;
  assign accept     = start_beat && (state_q == ST_IDLE) && out_free;
  assign drop       = start_beat && !accept;
  assign forward    = fft_valid && (accept || (state_q == ST_FORWARD));
  assign pop        = res_valid_q && res_ready;
  assign load       = (state_q == ST_WAIT_ENG) && eng_formant_valid;

  always_comb begin
    in_cnt_d     = in_cnt_q;
    drop_count_d = drop_count_q;
    if (fft_valid) in_cnt_d = (in_cnt_q == LAST_BEAT) ? '0 : in_cnt_q + CW'(1);
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
  end

`ifdef FORMANT_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0]       wd_q;
  logic [1:0]           rec_cnt_q;
  logic                 eng_rst_q;
  logic [CNT_WIDTH-1:0] timeout_count_q;

  assign eng_rst       = eng_rst_q;
  assign timeout_count = timeout_count_q;
`else
  assign eng_rst       = 1'b0;
  assign timeout_count = '0;
`endif

  // NOTE: every state bit, including the wide result register, has a defined reset value
  // because downstream logic may sample res_freq/res_seq straight out of reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      in_cnt_q        <= '0;
      accept_seq_q    <= '0;
      tag_q           <= '0;
      eng_fft_valid_q <= 1'b0;
      eng_fft_data_q  <= '0;
      res_valid_q     <= 1'b0;
      res_freq_q      <= '0;
      res_seq_q       <= '0;
      drop_count_q    <= '0;
`ifdef FORMANT_SCHED_TIMEOUT_EN
      wd_q            <= '0;
      rec_cnt_q       <= '0;
      eng_rst_q       <= 1'b0;
      timeout_count_q <= '0;
`endif
    end else begin
      in_cnt_q        <= in_cnt_d;
      drop_count_q    <= drop_count_d;
      eng_fft_valid_q <= forward;
      if (forward) eng_fft_data_q <= fft_data;

      // NOTE: non-blocking assignments; when pop and load coincide the later load wins,
      // leaving res_valid set with the new result.
      if (pop) res_valid_q <= 1'b0;
      if (load) begin
        res_valid_q <= 1'b1;
        res_freq_q  <= eng_formant_freq;
        res_seq_q   <= tag_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q        <= accept_seq_q;
            accept_seq_q <= accept_seq_q + 8'd1;
            state_q      <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (fft_valid && (in_cnt_q == LAST_BEAT)) begin
            state_q <= ST_WAIT_ENG;
`ifdef FORMANT_SCHED_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        ST_WAIT_ENG: begin
          if (eng_formant_valid) begin
            state_q <= ST_IDLE;
`ifdef FORMANT_SCHED_TIMEOUT_EN
          end else if (wd_q == WD_LAST) begin
            state_q   <= ST_RECOVER;
            eng_rst_q <= 1'b1;
            rec_cnt_q <= '0;
            if (timeout_count_q != '1) timeout_count_q <= timeout_count_q + CNT_WIDTH'(1);
          end else begin
            wd_q <= wd_q + WDW'(1);
`endif
          end
        end
        ST_RECOVER: begin
`ifdef FORMANT_SCHED_TIMEOUT_EN
          // Engine reset stays high for four cycles in this state.
          if (rec_cnt_q == 2'd3) begin
            eng_rst_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            rec_cnt_q <= rec_cnt_q + 2'd1;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eng_fft_valid = eng_fft_valid_q;
  assign eng_fft_data  = eng_fft_data_q;
  assign res_valid     = res_valid_q;
  assign res_freq      = res_freq_q;
  assign res_seq       = res_seq_q;
  assign drop_count    = drop_count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_formant_frame_scheduler.sv
// Scoreboard bench for formant_frame_scheduler (I=8, FORMANTS=5, TIMEOUT_CYCLES=50).
// Watchdog scenario adapts to FORMANT_SCHED_TIMEOUT_EN.
module tb_formant_frame_scheduler;
  localparam int BW = 32;
  localparam int NI = 8;
  localparam int NF = 5;
  localparam int TO = 50;
  localparam int CW = 16;
  localparam int FW = BW * NF;

  logic            clk_in, rst_in;
  logic            fft_valid;
  logic [BW-1:0]   fft_data;
  logic            eng_fft_valid;
  logic [BW-1:0]   eng_fft_data;
  logic            eng_rst;
  logic            eng_formant_valid;
  logic [FW-1:0]   eng_formant_freq;
  logic            res_valid, res_ready;
  logic [FW-1:0]   res_freq;
  logic [7:0]      res_seq;
  logic            busy;
  logic [CW-1:0]   drop_count, timeout_count;

  formant_frame_scheduler #(
    .BIT_WIDTH(BW), .I(NI), .FORMANTS(NF), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .fft_valid(fft_valid), .fft_data(fft_data),
    .eng_fft_valid(eng_fft_valid), .eng_fft_data(eng_fft_data), .eng_rst(eng_rst),
    .eng_formant_valid(eng_formant_valid), .eng_formant_freq(eng_formant_freq),
    .res_valid(res_valid), .res_ready(res_ready), .res_freq(res_freq), .res_seq(res_seq),
    .busy(busy), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  typedef struct {
    logic [BW-1:0] data;
    int unsigned   cyc;
  } beat_t;

  typedef struct {
    logic [FW-1:0] freq;
    logic [7:0]    seq;
  } res_t;

  beat_t       exp_beats[$];
  res_t        exp_res[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack5(input int a, input int b, input int c,
                                          input int d, input int e);
    logic [FW-1:0] r;
    r = '0;
    r[0*BW +: BW] = a;
    r[1*BW +: BW] = b;
    r[2*BW +: BW] = c;
    r[3*BW +: BW] = d;
    r[4*BW +: BW] = e;
    return r;
  endfunction

  // Monitor: forwarded beats and consumed results are popped against the scoreboard.
  always @(negedge clk_in) begin
    beat_t b;
    res_t  r;
    if (!rst_in && eng_fft_valid) begin
      if (exp_beats.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fwd_unexpected: got beat data %0d at cycle %0d, expected none",
                 eng_fft_data, cyc);
      end else begin
        b = exp_beats.pop_front();
        check("fwd_data", eng_fft_data, b.data);
        check("fwd_cycle", cyc, b.cyc);
      end
    end
    if (!rst_in && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL res_unexpected: got result seq %0d, expected none", res_seq);
      end else begin
        r = exp_res.pop_front();
        check("res_freq", res_freq, r.freq);
        check("res_seq", res_seq, r.seq);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      fft_valid = 1'b0;
    end
  endtask

  task automatic beat(input int d, input bit fwd);
    beat_t b;
    @(posedge clk_in); #1;
    fft_valid = 1'b1;
    fft_data  = d;
    if (fwd) begin
      b.data = d;
      b.cyc  = cyc + 1;
      exp_beats.push_back(b);
    end
  endtask

  task automatic send_frame(input int base, input bit fwd, input bit gaps);
    for (int k = 0; k < NI; k++) begin
      beat(base + k, fwd);
      if (gaps && k < NI - 1) idle(1);
    end
    idle(1);
  endtask

  task automatic pulse(input logic [FW-1:0] f, input logic [7:0] seq);
    res_t r;
    @(posedge clk_in); #1;
    eng_formant_valid = 1'b1;
    eng_formant_freq  = f;
    r.freq = f;
    r.seq  = seq;
    exp_res.push_back(r);
    @(posedge clk_in); #1;
    eng_formant_valid = 1'b0;
    @(negedge clk_in);
    check("res_valid_after_pulse", res_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first_rst;
    int rst_highs;
    rst_in = 1'b1; fft_valid = 1'b0; fft_data = '0;
    eng_formant_valid = 1'b0; eng_formant_freq = '0; res_ready = 1'b0;
    #12;
    check("rst_eng_fft_valid", eng_fft_valid, 1'b0);
    check("rst_eng_fft_data", eng_fft_data, '0);
    check("rst_eng_rst", eng_rst, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_freq", res_freq, '0);
    check("rst_res_seq", res_seq, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop_count", drop_count, '0);
    check("rst_timeout_count", timeout_count, '0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Single frame: data 1..8, result 20 cycles later, held until consumer accepts.
    send_frame(1, 1'b1, 1'b0);
    @(negedge clk_in);
    check("t1_busy_wait", busy, 1'b1);
    idle(20);
    pulse(pack5(100, 200, 300, 400, 500), 8'd0);
    check("t1_res_seq", res_seq, 8'd0);
    check("t1_res_freq", res_freq, pack5(100, 200, 300, 400, 500));
    check("t1_busy_idle", busy, 1'b0);
    @(posedge clk_in); #1;
    res_ready = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("t1_res_popped", res_valid, 1'b0);

    // Drop while busy: frame starting in WAIT_ENG is discarded, seq not consumed.
    send_frame(11, 1'b1, 1'b0);
    send_frame(21, 1'b0, 1'b0);
    @(negedge clk_in);
    check("t2_drop_count", drop_count, 16'd1);
    pulse(pack5(1, 2, 3, 4, 5), 8'd1);
    idle(2);

    // Output backpressure: full register drops a frame, then pop and start coincide.
    @(posedge clk_in); #1;
    res_ready = 1'b0;
    send_frame(31, 1'b1, 1'b0);
    idle(3);
    pulse(pack5(10, 20, 30, 40, 50), 8'd2);
    send_frame(41, 1'b0, 1'b0);
    @(negedge clk_in);
    check("t3_drop_count", drop_count, 16'd2);
    check("t3_res_valid_held", res_valid, 1'b1);
    check("t3_res_freq_held", res_freq, pack5(10, 20, 30, 40, 50));
    check("t3_res_seq_held", res_seq, 8'd2);
    @(posedge clk_in); #1;
    res_ready = 1'b1;
    fft_valid = 1'b1;
    fft_data  = 51;
    begin
      beat_t b;
      b.data = 51;
      b.cyc  = cyc + 1;
      exp_beats.push_back(b);
    end
    beat(52, 1'b1);
    @(negedge clk_in);
    check("t3_res_valid_fell", res_valid, 1'b0);
    check("t3_busy_accepted", busy, 1'b1);
    for (int k = 53; k <= 58; k++) beat(k, 1'b1);
    idle(3);
    pulse(pack5(7, 8, 9, 10, 11), 8'd3);

    // Input gaps: alternating strobe must be reproduced one cycle late.
    send_frame(61, 1'b1, 1'b1);
    @(negedge clk_in);
    check("t4_busy_wait", busy, 1'b1);
    pulse(pack5(600, 700, 800, 900, 1000), 8'd4);

    // Watchdog scenario.
    send_frame(71, 1'b1, 1'b0);
    first_rst = -1;
    rst_highs = 0;
`ifdef FORMANT_SCHED_TIMEOUT_EN
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk_in);
      if (eng_rst) begin
        if (first_rst < 0) first_rst = j;
        rst_highs++;
      end
    end
    check("t5_eng_rst_start", first_rst, TO + 1);
    check("t5_eng_rst_len", rst_highs, 4);
    check("t5_timeout_count", timeout_count, 16'd1);
    check("t5_res_valid", res_valid, 1'b0);
    check("t5_busy_idle", busy, 1'b0);
`else
    for (int j = 1; j <= 210; j++) begin
      @(negedge clk_in);
      if (eng_rst) rst_highs++;
    end
    check("t5_eng_rst_never", rst_highs, 0);
    check("t5_still_waiting", busy, 1'b1);
    check("t5_timeout_count", timeout_count, '0);
    pulse(pack5(5, 4, 3, 2, 1), 8'd5);
`endif

    // Async reset in the middle of a forwarded frame.
    for (int k = 0; k < 4; k++) beat(81 + k, 1'b1);
    @(posedge clk_in); #1;
    fft_valid = 1'b0;
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("t6_eng_fft_valid", eng_fft_valid, 1'b0);
    check("t6_eng_fft_data", eng_fft_data, '0);
    check("t6_busy", busy, 1'b0);
    check("t6_res_freq", res_freq, '0);
    check("t6_res_seq", res_seq, '0);
    check("t6_drop_count", drop_count, '0);
    check("t6_timeout_count", timeout_count, '0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send_frame(91, 1'b1, 1'b0);
    idle(2);
    pulse(pack5(11, 22, 33, 44, 55), 8'd0);
    idle(3);

    check("end_beats_drained", exp_beats.size(), 0);
    check("end_results_drained", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
